instruction_fetch: RTL and testbench

//  Upstream fetch stage for the RV32I controller: walks the PC, issues word reads
//  to instruction memory, buffers returned words with their PC in a small FIFO.

---
 rtl/instruction_fetch.sv | 185 ++++++++++++++++++
 tb/tb_instruction_fetch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: walks the PC, issues one-cycle word reads and buffers {pc, word} in a prefetch FIFO.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] PC_STEP   = 32'd4,
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] read_address,
   output logic [2:0]  funct3,
   input  logic [31:0] read_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        halted,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stalls
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t        state_r;
   state_t        state_next_s;
   logic [31:0]   pc_r;
   logic [31:0]   pc_q_r;
   logic          issue_q_r;
   logic          halted_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_next_s;
   logic [CW-1:0] occupancy_s;
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [31:0]   data_mem_r [DEPTH];
   logic [31:0]   pc_mem_r   [DEPTH];
   logic          deq_s;
   logic          resp_s;
   logic          push_s;
   logic          halt_seen_s;
   logic          issue_s;

   assign read_address = pc_r;
   assign funct3       = 3'b010;
   assign instr_valid  = (count_r != {CW{1'b0}});
   assign instr_data   = data_mem_r[rd_ptr_r];
   assign instr_pc     = pc_mem_r[rd_ptr_r];
   assign halted       = halted_r;

   // Issue decision, response classification and next-state/occupancy.
   always_comb begin
      deq_s        = instr_valid && instr_ready && !redirect_valid;
      occupancy_s  = count_r + CW'(issue_q_r) - CW'(deq_s);
      // Responses arriving after the halt word are speculative and dropped.
      resp_s       = issue_q_r && !redirect_valid && (state_r == ST_RUN);
      halt_seen_s  = resp_s && (read_data == HALT_WORD);
      push_s       = resp_s && (read_data != HALT_WORD);
      issue_s      = (state_r == ST_RUN) && !redirect_valid && (occupancy_s < DEPTH_C);
      state_next_s = state_r;
      count_next_s = count_r;
      if (redirect_valid) begin
         state_next_s = ST_RUN;
         count_next_s = {CW{1'b0}};
      end else begin
         if (halt_seen_s) begin
            state_next_s = ST_HALT;
         end else begin
            state_next_s = state_r;
         end
         case ({push_s, deq_s})
            2'b10:   count_next_s = count_r + CW'(1'b1);
            2'b01:   count_next_s = count_r - CW'(1'b1);
            default: count_next_s = count_r;
         endcase
      end
   end

   // PC, outstanding-read flag, FSM state and FIFO pointers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r      <= RESET_PC;
         pc_q_r    <= 32'h0000_0000;
         issue_q_r <= 1'b0;
         state_r   <= ST_RUN;
         halted_r  <= 1'b0;
         count_r   <= {CW{1'b0}};
         wr_ptr_r  <= {AW{1'b0}};
         rd_ptr_r  <= {AW{1'b0}};
      end else begin
         state_r  <= state_next_s;
         halted_r <= (state_next_s == ST_HALT);
         count_r  <= count_next_s;
         if (redirect_valid) begin
            pc_r      <= redirect_pc;
            issue_q_r <= 1'b0;
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
         end else begin
            issue_q_r <= issue_s;
            if (issue_s) begin
               pc_r   <= pc_r + PC_STEP;
               pc_q_r <= pc_r;
            end
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (deq_s) begin
               rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
         end
      end
   end

   // FIFO storage; cleared on reset so the head reads zero until filled.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            data_mem_r[i] <= 32'h0000_0000;
            pc_mem_r[i]   <= 32'h0000_0000;
         end
      end else if (push_s) begin
         data_mem_r[wr_ptr_r] <= read_data;
         pc_mem_r[wr_ptr_r]   <= pc_q_r;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_r;
   logic [31:0] perf_stalls_r;

   // Saturating accepted-instruction and RUN-starvation counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched_r <= 32'h0000_0000;
         perf_stalls_r  <= 32'h0000_0000;
      end else begin
         if (deq_s && (perf_fetched_r != 32'hFFFF_FFFF)) begin
            perf_fetched_r <= perf_fetched_r + 32'd1;
         end
         if ((state_r == ST_RUN) && !instr_valid && (perf_stalls_r != 32'hFFFF_FFFF)) begin
            perf_stalls_r <= perf_stalls_r + 32'd1;
         end
      end
   end

   assign perf_fetched = perf_fetched_r;
   assign perf_stalls  = perf_stalls_r;
`else
   assign perf_fetched = 32'h0000_0000;
   assign perf_stalls  = 32'h0000_0000;
`endif

   instruction_fetch_checker #(.DEPTH(DEPTH), .CW(CW)) u_checker (
      .clk   (clk),
      .reset (reset),
      .count (count_r)
   );

endmodule

// Occupancy bound for the prefetch FIFO.
module instruction_fetch_checker #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = 3
) (
   input logic          clk,
   input logic          reset,
   input logic [CW-1:0] count
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   a_count_bound: assert property (@(posedge clk) disable iff (reset) (count <= DEPTH_C));

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: in-order stream model plus directed latency/halt/redirect cases.
module tb_instruction_fetch;

   localparam logic [31:0] HALT = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] read_address;
   logic [2:0]  funct3;
   logic [31:0] read_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;
   logic [31:0] perf_fetched;
   logic [31:0] perf_stalls;

   logic [31:0] mem [64];
   int          checks = 0;
   int          errors = 0;

   // Stream model: next expected pc, handshake/stall tallies, halt bookkeeping.
   logic [31:0] exp_pc;
   int          hs_count;
   int          stall_count;
   int          starve_len;
   logic [31:0] prev_addr;
   logic        prev_halted;
   logic        prev_redirect;

   instruction_fetch dut (
      .clk            (clk),
      .reset          (reset),
      .read_address   (read_address),
      .funct3         (funct3),
      .read_data      (read_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted),
      .perf_fetched   (perf_fetched),
      .perf_stalls    (perf_stalls)
   );

   always #5 clk = ~clk;

   // One-cycle synchronous instruction memory.
   always @(posedge clk) read_data <= mem[read_address[7:2]];

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return mem[a[7:2]];
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_pc        = 32'h0000_0000;
      hs_count      = 0;
      stall_count   = 0;
      starve_len    = 0;
      prev_addr     = 32'h0000_0000;
      prev_halted   = 1'b0;
      prev_redirect = 1'b0;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_eq("rst_addr",   read_address, 32'h0);
      check_eq("rst_valid",  32'(instr_valid), 32'h0);
      check_eq("rst_data",   instr_data, 32'h0);
      check_eq("rst_pc",     instr_pc, 32'h0);
      check_eq("rst_halted", 32'(halted), 32'h0);
      check_eq("rst_perf_f", perf_fetched, 32'h0);
      check_eq("rst_perf_s", perf_stalls, 32'h0);
      reset = 1'b0;
      model_reset();
   endtask

   // Check this cycle against the model, update the model, then advance one clock.
   task automatic step();
      if (prev_halted && halted && !prev_redirect)
         check_eq("halt_addr_hold", read_address, prev_addr);
      if (halted && !instr_valid)
         check_eq("halt_at_word", word_at(exp_pc), HALT);
      starve_len = (!halted && !instr_valid) ? starve_len + 1 : 0;
      check_eq("starve", 32'(starve_len > 4), 32'h0);
      check_eq("funct3", 32'(funct3), 32'h2);
`ifdef FETCH_PERF_EN
      check_eq("perf_fetched", perf_fetched, 32'(hs_count));
      check_eq("perf_stalls", perf_stalls, 32'(stall_count));
`else
      check_eq("perf_fetched", perf_fetched, 32'h0);
      check_eq("perf_stalls", perf_stalls, 32'h0);
`endif
      if (!halted && !instr_valid) stall_count++;
      if (instr_valid && instr_ready && !redirect_valid) begin
         check_eq("deq_pc", instr_pc, exp_pc);
         check_eq("deq_data", instr_data, word_at(exp_pc));
         exp_pc = exp_pc + 32'd4;
         hs_count++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      prev_addr     = read_address;
      prev_halted   = halted;
      prev_redirect = redirect_valid;
      @(posedge clk); #1;
   endtask

   initial begin
      int          since_redir;
      logic [5:0]  widx;
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0013 + 32'(i);
      reset          = 1'b1;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;

      // Sequential fetch at full rate
      do_reset();
      instr_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         check_eq("t1_addr", read_address, 32'(4 * c));
         check_eq("t1_valid", 32'(instr_valid), 32'(c >= 2));
         if (c >= 2) check_eq("t1_pc", instr_pc, 32'(4 * (c - 2)));
         step();
      end

      // Back-pressure fills the FIFO, then drains in order
      do_reset();
      instr_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (c >= 4) check_eq("t2_freeze", read_address, 32'd16);
         step();
      end
      check_eq("t2_valid", 32'(instr_valid), 32'h1);
      check_eq("t2_head", instr_pc, 32'h0);
      instr_ready = 1'b1;
      step();
      check_eq("t2_resume", read_address, 32'd20);
      for (int c = 0; c < 3; c++) step();
      check_eq("t2_drained", 32'(hs_count), 32'd4);

      // Reset with the FIFO full
      instr_ready = 1'b0;
      for (int c = 0; c < 6; c++) step();
      do_reset();

      // Halt word at address 8, then redirect out of HALT
      mem[2] = HALT;
      instr_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         check_eq("t3_halted", 32'(halted), 32'(c >= 4));
         step();
      end
      check_eq("t3_delivered", 32'(hs_count), 32'd2);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h20;
      step();
      redirect_valid = 1'b0;
      check_eq("t5_halted", 32'(halted), 32'h0);
      check_eq("t5_addr", read_address, 32'h20);
      for (int c = 0; c < 6; c++) step();
      mem[2] = 32'h1000_0015;

      // Redirect while FIFO holds three entries and consumer is ready
      do_reset();
      instr_ready = 1'b0;
      for (int c = 0; c < 4; c++) step();
      instr_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      step();
      redirect_valid = 1'b0;
      check_eq("t4_valid0", 32'(instr_valid), 32'h0);
      check_eq("t4_addr", read_address, 32'h40);
      step();
      check_eq("t4_valid1", 32'(instr_valid), 32'h0);
      step();
      check_eq("t4_valid2", 32'(instr_valid), 32'h1);
      check_eq("t4_first_pc", instr_pc, 32'h40);
      for (int c = 0; c < 4; c++) step();

      // PC wraps past the top of the address space
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      step();
      redirect_valid = 1'b0;
      for (int c = 0; c < 8; c++) step();

      // Random memory image, back-pressure and redirects
      for (int i = 0; i < 64; i++)
         mem[i] = ($urandom_range(0, 15) == 0) ? HALT : ($urandom | 32'h1);
      do_reset();
      since_redir = 0;
      for (int n = 0; n < 2000; n++) begin
         instr_ready = ($urandom_range(0, 3) != 0);
         since_redir++;
         if (since_redir > 5 && $urandom_range(0, halted ? 3 : 40) == 0) begin
            widx           = 6'($urandom_range(0, 63));
            redirect_valid = 1'b1;
            redirect_pc    = {24'h0, widx, 2'b00};
            since_redir    = 0;
         end else begin
            redirect_valid = 1'b0;
         end
         step();
      end
      redirect_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
